// File: rtl/adc_scan_sequencer.sv
// Scan controller for an 8-channel 12-bit SPI ADC with CONVST on cs_n.
// Walks the latched channel mask in ascending order and accounts for the ADC's one-frame config latency.
module adc_scan_sequencer #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  ch_enable,
    input  logic        start,
    input  logic        continuous,
    output logic        busy,
    output logic        adc_sclk,
    output logic        adc_cs_n,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic        result_valid,
    output logic [2:0]  result_ch,
    output logic [11:0] result_data,
    output logic        scan_done
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CONV_W = $clog2(CONV_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CONV, SHIFT} state_t;

    state_t            state;
    logic [7:0]        mask;
    logic [2:0]        cfg_ch;
    logic [2:0]        data_ch;
    logic              prime;
    logic              last;
    logic [CONV_W-1:0] conv_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [4:0]        half_cnt;
    logic [4:0]        half_nxt;
    logic [11:0]       shreg;
    logic [5:0]        cfg_cur;
    logic [3:0]        nxt;
    logic [2:0]        first_ch;

    function automatic logic [2:0] lowest_ch(input logic [7:0] m);
        lowest_ch = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i]) lowest_ch = 3'(i);
    endfunction

    // Returns {found, channel} for the lowest enabled channel strictly above c; no wrap.
    function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] c);
        next_ch = 4'd0;
        for (int i = 7; i >= 0; i--)
            if (m[i] && (i > int'(c))) next_ch = {1'b1, 3'(i)};
    endfunction

    function automatic logic [5:0] cfg_word(input logic [2:0] c);
        cfg_word = {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
    endfunction

    function automatic logic din_bit(input logic [5:0] cfg, input logic [3:0] idx);
        din_bit = 1'b0;
        if (idx < 4'd6) din_bit = cfg[3'(4'd5 - idx)];
    endfunction

    assign cfg_cur  = cfg_word(cfg_ch);
    assign nxt      = next_ch(mask, cfg_ch);
    assign first_ch = lowest_ch(mask);
    assign half_nxt = half_cnt + 5'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            mask         <= 8'd0;
            cfg_ch       <= 3'd0;
            data_ch      <= 3'd0;
            prime        <= 1'b0;
            last         <= 1'b0;
            conv_cnt     <= '0;
            div_cnt      <= '0;
            half_cnt     <= 5'd0;
            shreg        <= 12'd0;
            busy         <= 1'b0;
            adc_sclk     <= 1'b0;
            adc_cs_n     <= 1'b1;
            adc_din      <= 1'b0;
            result_valid <= 1'b0;
            result_ch    <= 3'd0;
            result_data  <= 12'd0;
            scan_done    <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            scan_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (ch_enable != 8'd0)) begin
                        mask     <= ch_enable;
                        cfg_ch   <= lowest_ch(ch_enable);
                        prime    <= 1'b1;
                        last     <= 1'b0;
                        busy     <= 1'b1;
                        conv_cnt <= '0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (conv_cnt == CONV_LAST) begin
                        state    <= SHIFT;
                        adc_cs_n <= 1'b0;
                        adc_din  <= cfg_cur[5];
                        div_cnt  <= '0;
                        half_cnt <= 5'd0;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else if (half_cnt != 5'd23) begin
                        // Odd half-periods are sclk-high: sample on entry, update din on the falling side.
                        div_cnt  <= '0;
                        half_cnt <= half_nxt;
                        adc_sclk <= half_nxt[0];
                        if (half_nxt[0])
                            shreg <= {shreg[10:0], adc_dout};
                        else
                            adc_din <= din_bit(cfg_cur, half_nxt[4:1]);
                    end else begin
                        div_cnt  <= '0;
                        adc_cs_n <= 1'b1;
                        adc_sclk <= 1'b0;
                        adc_din  <= 1'b0;
                        conv_cnt <= '0;
                        if (!prime) begin
                            result_valid <= 1'b1;
                            result_ch    <= data_ch;
                            result_data  <= shreg;
                        end
                        if (last) begin
                            scan_done <= 1'b1;
                            if (continuous && (ch_enable != 8'd0)) begin
                                mask   <= ch_enable;
                                cfg_ch <= lowest_ch(ch_enable);
                                prime  <= 1'b1;
                                last   <= 1'b0;
                                state  <= CONV;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            // Running out of higher channels means the next frame only resends the first cfg.
                            data_ch <= cfg_ch;
                            prime   <= 1'b0;
                            state   <= CONV;
                            if (nxt[3]) begin
                                cfg_ch <= nxt[2:0];
                                last   <= 1'b0;
                            end else begin
                                cfg_ch <= first_ch;
                                last   <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: two instances (default timing and CLK_DIV=1/CONV_CYCLES=2),
// a behavioural ADC per instance, and a result/config scoreboard.
module tb_adc_scan_sequencer;

    typedef struct {
        int inst;
        int ch;
        int data;
        int done;
        int busy;
        int cyc;
    } res_t;

    typedef struct {
        int inst;
        int cfg;
    } cfg_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0][7:0]  ch_enable = '0;
    logic [1:0]       start = '0;
    logic [1:0]       continuous = '0;
    logic [1:0]       busy;
    logic [1:0]       adc_sclk;
    logic [1:0]       adc_cs_n;
    logic [1:0]       adc_din;
    logic [1:0]       adc_dout = '0;
    logic [1:0]       result_valid;
    logic [1:0][2:0]  result_ch;
    logic [1:0][11:0] result_data;
    logic [1:0]       scan_done;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_res = 0;
    int n_cfg = 0;
    int div_of [2] = '{2, 1};
    int conv_of [2] = '{80, 2};
    logic [11:0] adc_val [8] = '{12'hA50, 12'h3C1, 12'h5AF, 12'h0F3, 12'h800, 12'hFFF, 12'h001, 12'h7E4};

    res_t res_q [$];
    cfg_t cfg_q [$];
    res_t mon_e;
    cfg_t mdl_e;

    logic [1:0]  m_cs_prev = 2'b11;
    logic [1:0]  m_sclk_prev = 2'b00;
    logic [1:0]  m_abort = 2'b11;
    logic [11:0] m_sr [2] = '{12'h0, 12'h0};
    logic [5:0]  m_cfg [2] = '{6'h0, 6'h0};
    logic [2:0]  m_sel [2] = '{3'd0, 3'd0};
    int          m_rises [2] = '{0, 0};
    int          m_high [2] = '{0, 0};
    int          m_run [2] = '{0, 0};

    adc_scan_sequencer #(.CLK_DIV(2), .CONV_CYCLES(80)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable[0]), .start(start[0]),
        .continuous(continuous[0]), .busy(busy[0]), .adc_sclk(adc_sclk[0]),
        .adc_cs_n(adc_cs_n[0]), .adc_din(adc_din[0]), .adc_dout(adc_dout[0]),
        .result_valid(result_valid[0]), .result_ch(result_ch[0]),
        .result_data(result_data[0]), .scan_done(scan_done[0])
    );

    adc_scan_sequencer #(.CLK_DIV(1), .CONV_CYCLES(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .ch_enable(ch_enable[1]), .start(start[1]),
        .continuous(continuous[1]), .busy(busy[1]), .adc_sclk(adc_sclk[1]),
        .adc_cs_n(adc_cs_n[1]), .adc_din(adc_din[1]), .adc_dout(adc_dout[1]),
        .result_valid(result_valid[1]), .result_ch(result_ch[1]),
        .result_data(result_data[1]), .scan_done(scan_done[1])
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, expected finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand-derived config words {S/D,O/S,S1,S0,UNI,SLP} per channel.
    function automatic int cfg_lit(input int c);
        case (c)
            0: cfg_lit = 6'b100010;
            1: cfg_lit = 6'b110010;
            2: cfg_lit = 6'b100110;
            3: cfg_lit = 6'b110110;
            4: cfg_lit = 6'b101010;
            5: cfg_lit = 6'b111010;
            6: cfg_lit = 6'b101110;
            default: cfg_lit = 6'b111110;
        endcase
    endfunction

    task automatic push_res(input int inst, input int ch, input int data, input int done,
                            input int bsy, input int at);
        res_q.push_back('{inst, ch, data, done, bsy, at});
    endtask

    task automatic push_cfg(input int inst, input int cfg);
        cfg_q.push_back('{inst, cfg});
    endtask

    task automatic pulse_start(input int i, output int t0);
        @(posedge clk);
        #1;
        t0 = cyc;
        start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((res_q.size() != 0 || cfg_q.size() != 0 || busy != 2'b00) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", res_q.size() + cfg_q.size() + int'(busy != 2'b00), 0);
        repeat (3) @(negedge clk);
    endtask

    // Behavioural ADC: data for the channel configured in the previous complete frame, MSB first.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) m_abort[i] = 1'b1;
            if (!busy[i]) m_run[i] = 0;
            else if (adc_cs_n[i]) m_run[i]++;
            if (m_cs_prev[i] && !adc_cs_n[i]) begin
                check($sformatf("conv_len_inst%0d", i), m_run[i], conv_of[i]);
                m_run[i] = 0;
                m_sr[i] = adc_val[m_sel[i]];
                m_rises[i] = 0;
                m_high[i] = 0;
                m_cfg[i] = 6'd0;
                m_abort[i] = 1'b0;
            end
            if (!adc_cs_n[i]) begin
                if (adc_sclk[i] && !m_sclk_prev[i]) begin
                    m_rises[i]++;
                    if (m_rises[i] <= 6) m_cfg[i] = {m_cfg[i][4:0], adc_din[i]};
                end
                if (!adc_sclk[i] && m_sclk_prev[i]) m_sr[i] = {m_sr[i][10:0], 1'b0};
                if (adc_sclk[i]) m_high[i]++;
            end
            if (!m_cs_prev[i] && adc_cs_n[i] && !m_abort[i]) begin
                check($sformatf("sclk_rises_inst%0d", i), m_rises[i], 12);
                check($sformatf("sclk_high_cycles_inst%0d", i), m_high[i], 12 * div_of[i]);
                if (cfg_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL cfg_unexpected inst%0d: got cfg 0x%0h, expected no frame", i, m_cfg[i]);
                end else begin
                    mdl_e = cfg_q.pop_front();
                    check($sformatf("cfg%0d (inst<<8|cfg)", n_cfg), (i << 8) | int'(m_cfg[i]),
                          (mdl_e.inst << 8) | mdl_e.cfg);
                    n_cfg++;
                end
                m_sel[i] = {m_cfg[i][3], m_cfg[i][2], m_cfg[i][4]};
            end
            adc_dout[i] = m_sr[i][11];
            m_cs_prev[i] = adc_cs_n[i];
            m_sclk_prev[i] = adc_sclk[i];
        end
    end

    initial forever begin
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (result_valid[i] || scan_done[i]) begin
                if (res_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL result_unexpected inst%0d: got ch %0d data 0x%0h at cycle %0d, expected none",
                             i, result_ch[i], result_data[i], cyc);
                end else begin
                    mon_e = res_q.pop_front();
                    check($sformatf("res%0d_inst", n_res), i, mon_e.inst);
                    check($sformatf("res%0d_valid", n_res), int'(result_valid[i]), 1);
                    check($sformatf("res%0d_ch", n_res), int'(result_ch[i]), mon_e.ch);
                    check($sformatf("res%0d_data", n_res), int'(result_data[i]), mon_e.data);
                    check($sformatf("res%0d_done", n_res), int'(scan_done[i]), mon_e.done);
                    check($sformatf("res%0d_busy", n_res), int'(busy[i]), mon_e.busy);
                    check($sformatf("res%0d_cycle", n_res), cyc, mon_e.cyc);
                    n_res++;
                end
            end
        end
    end

    initial begin
        int t0;
        int tx;

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_cs_n%0d", i), int'(adc_cs_n[i]), 1);
            check($sformatf("rst_sclk%0d", i), int'(adc_sclk[i]), 0);
            check($sformatf("rst_din%0d", i), int'(adc_din[i]), 0);
            check($sformatf("rst_busy%0d", i), int'(busy[i]), 0);
            check($sformatf("rst_valid%0d", i), int'(result_valid[i]), 0);
            check($sformatf("rst_ch%0d", i), int'(result_ch[i]), 0);
            check($sformatf("rst_data%0d", i), int'(result_data[i]), 0);
            check($sformatf("rst_done%0d", i), int'(scan_done[i]), 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Start with an empty mask is ignored.
        ch_enable[0] = 8'h00;
        pulse_start(0, t0);
        repeat (5) @(negedge clk);
        check("mask0_busy", int'(busy[0]), 0);
        check("mask0_cs_n", int'(adc_cs_n[0]), 1);

        // Channels 0 and 2.
        ch_enable[0] = 8'h05;
        pulse_start(0, t0);
        push_cfg(0, 6'b100010);
        push_cfg(0, 6'b100110);
        push_cfg(0, 6'b100010);
        push_res(0, 0, 12'hA50, 0, 1, t0 + 257);
        push_res(0, 2, 12'h5AF, 1, 0, t0 + 385);
        drain(1000);

        // Channel 7 alone, with ignored start pulses while busy.
        ch_enable[0] = 8'h80;
        pulse_start(0, t0);
        push_cfg(0, 6'b111110);
        push_cfg(0, 6'b111110);
        push_res(0, 7, 12'h7E4, 1, 0, t0 + 257);
        wait_until(t0 + 50);
        pulse_start(0, tx);
        wait_until(t0 + 200);
        pulse_start(0, tx);
        drain(1000);

        // Continuous: mask changed mid-scan only affects the following scan.
        continuous[0] = 1'b1;
        ch_enable[0] = 8'h03;
        pulse_start(0, t0);
        push_cfg(0, 6'b100010);
        push_cfg(0, 6'b110010);
        push_cfg(0, 6'b100010);
        push_cfg(0, 6'b110110);
        push_cfg(0, 6'b110110);
        push_res(0, 0, 12'hA50, 0, 1, t0 + 257);
        push_res(0, 1, 12'h3C1, 1, 1, t0 + 385);
        push_res(0, 3, 12'h0F3, 1, 0, t0 + 641);
        wait_until(t0 + 100);
        ch_enable[0] = 8'h08;
        wait_until(t0 + 450);
        continuous[0] = 1'b0;
        drain(1500);

        // Reset in the middle of a SHIFT window abandons the frame.
        ch_enable[0] = 8'h05;
        pulse_start(0, t0);
        wait_until(t0 + 100);
        reset_n = 1'b0;
        #1;
        check("abort_cs_n", int'(adc_cs_n[0]), 1);
        check("abort_sclk", int'(adc_sclk[0]), 0);
        repeat (3) @(negedge clk);
        check("abort_busy", int'(busy[0]), 0);
        check("abort_ch", int'(result_ch[0]), 0);
        check("abort_data", int'(result_data[0]), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulse_start(0, t0);
        push_cfg(0, 6'b100010);
        push_cfg(0, 6'b100110);
        push_cfg(0, 6'b100010);
        push_res(0, 0, 12'hA50, 0, 1, t0 + 257);
        push_res(0, 2, 12'h5AF, 1, 0, t0 + 385);
        drain(1000);

        // Fast instance, every channel: 26-cycle frames.
        ch_enable[1] = 8'hFF;
        pulse_start(1, t0);
        for (int c = 0; c < 8; c++) push_cfg(1, cfg_lit(c));
        push_cfg(1, cfg_lit(0));
        for (int j = 1; j <= 8; j++)
            push_res(1, j - 1, int'(adc_val[j - 1]), int'(j == 8), int'(j != 8), t0 + 1 + (j + 1) * 26);
        drain(600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Scan controller for the board's 8-channel, 12-bit SPI ADC (LTC2308-style, CONVST shared with cs_n), which sits behind the adc_external_interface pins.
- Converts each channel set in a latched enable mask in ascending order, one shot or continuous, and drives the ADC's sclk/cs_n/din/dout protocol.
- Emits one result strobe per channel, tagged with the channel number, for the mixer's sensor logic.
- Handles the ADC's one-frame config pipeline: the config sent in frame k selects the channel whose data is read in frame k+1.

Parameters:
CLK_DIV, 2, clk cycles per sclk half-period (>=1)
CONV_CYCLES, 80, clk cycles cs_n held high per frame for conversion (>=2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ch_enable  in  8  channel mask, bit n = channel n; latched at scan start
start  in  1  single-cycle scan request; honoured only in IDLE with ch_enable!=0
continuous  in  1  1 = restart a new scan (re-latch mask) immediately after scan_done
busy  out  1  high from cycle after accepted start until return to IDLE
adc_sclk  out  1  SPI clock, idles low
adc_cs_n  out  1  chip select / CONVST, idles high
adc_din  out  1  config bit to ADC
adc_dout  in  1  data bit from ADC
result_valid  out  1  one-cycle strobe, result_ch/result_data valid
result_ch  out  3  channel of current result
result_data  out  12  conversion result, unsigned
scan_done  out  1  one-cycle strobe coincident with last result_valid of a scan

Behaviour:
- Reset (async, any state): FSM->IDLE; adc_cs_n=1, adc_sclk=0, adc_din=0, busy=0, result_valid=0, result_ch=0, result_data=0, scan_done=0; counters and latched mask cleared. An in-flight frame is abandoned and nothing is emitted.
- States: IDLE -> CONV -> SHIFT -> (CONV | IDLE).
- IDLE:
  - start=1 and ch_enable!=0: latch mask (M = popcount), busy=1, enter CONV next cycle.
  - start with mask 0 is ignored.
  - start while busy is ignored.
- CONV: adc_cs_n=1, adc_sclk=0 for exactly CONV_CYCLES cycles, then SHIFT.
- SHIFT, 24*CLK_DIV cycles:
  - adc_cs_n=0; adc_sclk toggles every CLK_DIV cycles, starting low, giving 12 rising edges and ending low.
  - adc_din holds config bit i (MSB first) during the low phase before rising edge i, i=0..5; 0 afterwards.
  - adc_dout is sampled on each rising edge into a 12-bit shift register, MSB first.
- Frame length = CONV_CYCLES + 24*CLK_DIV (128 with defaults).
- Config word for channel c: {S/D=1, O/S=c[0], S1=c[2], S0=c[1], UNI=1, SLP=0}.
- Frame sequence per scan: M+1 frames.
  - Frame 0 sends the cfg of the lowest enabled channel; its read data is discarded.
  - Frame j (1..M) sends the cfg of the (j+1)th enabled channel (frame M resends the first; harmless) and reads the data of the jth enabled channel.
- Output after frames 1..M: in the first cycle after SHIFT ends, result_valid=1 for one cycle; result_data = shift register; result_ch = channel whose cfg was sent in the previous frame. result_ch/result_data hold until the next strobe.
- scan_done pulses with the result of frame M. After frame M:
  - continuous=0: go to IDLE; busy drops the same cycle as scan_done.
  - continuous=1: re-latch ch_enable (if 0, go to IDLE) and go to CONV with a new priming frame.
- ch_enable changes mid-scan have no effect on the current scan.
- Channel search wraps from 7 to 0 only for the frame-M resend.

Test Plan:
- Reset values: hold reset_n=0 -> all outputs at reset values. Release; pulse start with ch_enable=0 -> busy stays 0, cs_n stays 1.
- ch_enable=8'b00000101, ADC model returns 12'hA50 for ch0 and 12'h5AF for ch2, start at t0:
  - din frame cfgs 100010, 100110, 100010.
  - result_valid at t0+257 (ch0, 12'hA50) and t0+385 (ch2, 12'h5AF).
  - scan_done at t0+385; busy low from t0+385.
- ch_enable=8'h80 -> cfg 111110; single result, ch=7; sclk period 4 cycles, exactly 12 rising edges per cs_n-low window; cs_n high exactly 80 cycles per frame.
- continuous=1 with mask 8'h03, then change mask to 8'h08 mid-scan:
  - Current scan reports ch0 then ch1.
  - Next scan primes and reports ch3 only.
  - Drop continuous -> IDLE after that scan.
- start pulses during busy -> ignored, result count unchanged. Assert reset_n=0 mid-SHIFT -> cs_n=1 and sclk=0 immediately; no result_valid; a fresh start after release behaves as in scenario 2.
- CLK_DIV=1, CONV_CYCLES=2 build: mask 8'hFF -> 8 results, ch 0..7 in order, frame length 26 cycles, scan_done with ch7.
